freelist: RTL and testbench

Physical-register free list for the 4-wide rename/dispatch path. It hands out four free physical destination tags per dispatch group and takes back four tags per commit group from the reorder buffer's commit port. Per-branch head checkpoints allow single-cycle rollback of speculative allocations on misprediction. It sits beside the rename map: allocation feeds `i_dis_prd4x` of the reorder buffer, and release is driven by the buffer's `o_com_prd4x`/`o_com_en`.

---
 rtl/core_pkg.sv | 19 +
 rtl/freelist_ckpt.sv | 35 +++
 rtl/freelist.sv | 89 ++++++++
 tb/tb_freelist.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared rename-path constants, tag type and the one-hot index encoder.
package core_pkg;
   localparam int NBANK         = 4;
   localparam int NARCH         = 32;
   localparam int WIDTH_REG_DEF = 7;
   localparam int WIDTH_BRM_DEF = 4;

   typedef logic [WIDTH_REG_DEF-1:0] ptag_t;

   // Index of the set bit; a non-one-hot input yields the OR of indices.
   function automatic logic [4:0] onehot_to_idx(input logic [31:0] i_oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (i_oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/freelist_ckpt.sv
// Per-branch free-list head checkpoints: one-hot save, one-hot restore read.
module freelist_ckpt
   import core_pkg::*;
#(
   parameter int WIDTH_REG = WIDTH_REG_DEF,
   parameter int WIDTH_BRM = WIDTH_BRM_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [WIDTH_BRM-1:0] i_save,
   input  logic [WIDTH_REG-1:0] i_save_head,
   input  logic [WIDTH_BRM-1:0] i_rd_sel,
   output logic [WIDTH_REG-1:0] o_rd_head
);
   logic [WIDTH_REG-1:0] r_ckpt [WIDTH_BRM];
   logic [4:0]           w_idx;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int b = 0; b < WIDTH_BRM; b++) r_ckpt[b] <= '0;
      end else begin
         for (int b = 0; b < WIDTH_BRM; b++) begin
            if (i_save[b]) r_ckpt[b] <= i_save_head;
         end
      end
   end

   always_comb begin
      w_idx     = onehot_to_idx(32'(i_rd_sel));
      o_rd_head = '0;
      for (int b = 0; b < WIDTH_BRM; b++) begin
         if (w_idx == 5'(b)) o_rd_head = r_ckpt[b];
      end
   end
endmodule

// File: rtl/freelist.sv
// Physical-register free list: 4-wide allocate/release circular buffer with
// per-branch head checkpoints for single-cycle mispredict rollback.
module freelist
   import core_pkg::*;
#(
   parameter int WIDTH_REG = WIDTH_REG_DEF,
   parameter int WIDTH_BRM = WIDTH_BRM_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   output logic [4*WIDTH_REG-1:0] o_alloc_prd4x,
   output logic                   o_alloc_rdy,
   output logic [WIDTH_REG-1:0]   o_free_cnt,
   input  logic                   i_alloc_re,
   input  logic [4*WIDTH_REG-1:0] i_com_prd4x,
   input  logic                   i_com_en,
   input  logic [WIDTH_BRM-1:0]   i_brm_save,
   input  logic                   i_rec_en,
   input  logic [WIDTH_BRM-1:0]   i_rec_tag
);
   localparam int                   NPREG   = 2**WIDTH_REG;
   localparam logic [WIDTH_REG-1:0] CNT_MAX = WIDTH_REG'(NPREG - NARCH);
   localparam logic [WIDTH_REG-1:0] GROUP   = WIDTH_REG'(NBANK);

   logic [WIDTH_REG-1:0] r_mem [NPREG];
   logic [WIDTH_REG-1:0] r_head;
   logic [WIDTH_REG-1:0] r_tail;
   logic [WIDTH_REG-1:0] r_cnt;

   logic                 w_alloc;
   logic [WIDTH_REG-1:0] w_head_alloc;
   logic [WIDTH_REG-1:0] w_head_next;
   logic [WIDTH_REG-1:0] w_tail_next;
   logic [WIDTH_REG-1:0] w_ckpt_head;
   logic [WIDTH_BRM-1:0] w_save;

   assign o_alloc_rdy  = i_rst_n & (r_cnt >= GROUP);
   assign o_free_cnt   = r_cnt;
   assign w_alloc      = i_alloc_re & o_alloc_rdy & ~i_rec_en;
   assign w_head_alloc = w_alloc ? r_head + GROUP : r_head;
   assign w_head_next  = i_rec_en ? w_ckpt_head : w_head_alloc;
   assign w_tail_next  = i_com_en ? r_tail + GROUP : r_tail;
   // A recovering cycle must not overwrite checkpoints with a doomed head.
   assign w_save       = i_brm_save & {WIDTH_BRM{~i_rec_en}};

   always_comb begin
      o_alloc_prd4x = '0;
      for (int j = 0; j < NBANK; j++) begin
         o_alloc_prd4x[j*WIDTH_REG +: WIDTH_REG] = r_mem[r_head + WIDTH_REG'(j)];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NPREG; k++) begin
            r_mem[k] <= (k < NPREG - NARCH) ? WIDTH_REG'(k + NARCH) : '0;
         end
         r_head <= '0;
         r_tail <= CNT_MAX;
         r_cnt  <= CNT_MAX;
      end else begin
         if (i_com_en) begin
            for (int j = 0; j < NBANK; j++) begin
               r_mem[r_tail + WIDTH_REG'(j)] <= i_com_prd4x[j*WIDTH_REG +: WIDTH_REG];
            end
         end
         r_head <= w_head_next;
         r_tail <= w_tail_next;
         r_cnt  <= w_tail_next - w_head_next;
      end
   end

   freelist_ckpt #(
      .WIDTH_REG (WIDTH_REG),
      .WIDTH_BRM (WIDTH_BRM)
   ) u_ckpt (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_save      (w_save),
      .i_save_head (w_head_alloc),
      .i_rd_sel    (i_rec_tag),
      .o_rd_head   (w_ckpt_head)
   );

   a_rec_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_rec_en |-> $onehot(i_rec_tag));
   a_cnt_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      r_cnt <= CNT_MAX);
endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist with a scoreboard driven by an unbounded tag-history model.
module tb_freelist;
   localparam int WR = 7;
   localparam int WB = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [4*WR-1:0] alloc_prd4x;
   logic            alloc_rdy;
   logic [WR-1:0]   free_cnt;
   logic            alloc_re;
   logic [4*WR-1:0] com_prd4x;
   logic            com_en;
   logic [WB-1:0]   brm_save;
   logic            rec_en;
   logic [WB-1:0]   rec_tag;

   always #5 clk = ~clk;

   freelist #(.WIDTH_REG(WR), .WIDTH_BRM(WB)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_alloc_prd4x (alloc_prd4x),
      .o_alloc_rdy   (alloc_rdy),
      .o_free_cnt    (free_cnt),
      .i_alloc_re    (alloc_re),
      .i_com_prd4x   (com_prd4x),
      .i_com_en      (com_en),
      .i_brm_save    (brm_save),
      .i_rec_en      (rec_en),
      .i_rec_tag     (rec_tag)
   );

   typedef struct {
      string         tag;
      logic [4*WR-1:0] prd;
      logic          rdy;
      logic [WR-1:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   hist[$];
   int   m_head;
   int   m_tail;
   int   m_ckpt[WB];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 32; k < 128; k++) hist.push_back(k);
      m_head = 0;
      m_tail = 96;
      for (int b = 0; b < WB; b++) m_ckpt[b] = 0;
   endtask

   function automatic logic [4*WR-1:0] model_prd();
      logic [4*WR-1:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) begin
         if (m_head + j < hist.size()) r[j*WR +: WR] = WR'(hist[m_head + j]);
      end
      return r;
   endfunction

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag = tag;
      e.rdy = (m_tail - m_head) >= 4;
      e.cnt = WR'(m_tail - m_head);
      e.prd = e.rdy ? model_prd() : '0;
      sbq.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({e.tag, "_rdy"}, 32'(alloc_rdy), 32'(e.rdy));
         chk({e.tag, "_cnt"}, 32'(free_cnt), 32'(e.cnt));
         if (e.rdy) chk({e.tag, "_prd"}, 32'(alloc_prd4x), 32'(e.prd));
      end
   endtask

   task automatic step(input logic a, input logic c, input logic [4*WR-1:0] cprd,
                       input logic [WB-1:0] save, input logic r, input logic [WB-1:0] rtag,
                       input string tag);
      bit rdy;
      int hn;
      alloc_re  = a;
      com_en    = c;
      com_prd4x = cprd;
      brm_save  = save;
      rec_en    = r;
      rec_tag   = rtag;
      rdy = (m_tail - m_head) >= 4;
      if (a && !rdy) $display("note: %s drives i_alloc_re while o_alloc_rdy=0", tag);
      hn = m_head + ((a && rdy && !r) ? 4 : 0);
      if (!r) begin
         for (int b = 0; b < WB; b++) if (save[b]) m_ckpt[b] = hn;
      end else begin
         for (int b = 0; b < WB; b++) if (rtag[b]) hn = m_ckpt[b];
      end
      if (c) begin
         for (int j = 0; j < 4; j++) hist.push_back(int'(cprd[j*WR +: WR]));
         m_tail += 4;
      end
      m_head = hn;
      push_exp(tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      alloc_re  = 1'b0;
      com_en    = 1'b0;
      com_prd4x = '0;
      brm_save  = '0;
      rec_en    = 1'b0;
      rec_tag   = '0;
      @(posedge clk);
      #1;
      chk({tag, "_rdy_in_rst"}, 32'(alloc_rdy), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4*WR-1:0] cp;

      // Reset and first idle cycle
      do_reset("t1");
      idle("t1_idle");
      chk("t1_prd_const", 32'(alloc_prd4x), 32'({7'd35, 7'd34, 7'd33, 7'd32}));
      chk("t1_cnt_const", 32'(free_cnt), 32'd96);

      // Drain all 24 groups, then an ignored extra request
      for (int i = 0; i < 23; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t2_alloc");
      chk("t2_last_grp", 32'(alloc_prd4x), 32'({7'd127, 7'd126, 7'd125, 7'd124}));
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t2_alloc_last");
      chk("t2_empty_rdy", 32'(alloc_rdy), 32'd0);
      chk("t2_empty_cnt", 32'(free_cnt), 32'd0);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t2_over");

      // Release into an empty list
      step(1'b0, 1'b1, {7'd3, 7'd2, 7'd1, 7'd0}, '0, 1'b0, '0, "t3_com");
      chk("t3_prd_const", 32'(alloc_prd4x), 32'({7'd3, 7'd2, 7'd1, 7'd0}));
      chk("t3_cnt_const", 32'(free_cnt), 32'd4);

      // Steady allocate+release across pointer wrap
      for (int i = 0; i < 40; i++) begin
         cp = model_prd();
         step(1'b1, 1'b1, cp, '0, 1'b0, '0, "t4_both");
      end
      chk("t4_cnt_const", 32'(free_cnt), 32'd4);

      // Checkpoint then recover
      do_reset("t5");
      idle("t5_idle");
      step(1'b1, 1'b0, '0, 4'b0110, 1'b0, '0, "t5_save");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t5_alloc");
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'b0010, "t5_rec");
      chk("t5_cnt_const", 32'(free_cnt), 32'd92);
      chk("t5_prd_const", 32'(alloc_prd4x), 32'({7'd39, 7'd38, 7'd37, 7'd36}));

      // Recovery with simultaneous release, allocate request and save
      step(1'b1, 1'b0, '0, 4'b0001, 1'b0, '0, "t6_save");
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t6_alloc");
      step(1'b1, 1'b1, {7'd13, 7'd12, 7'd11, 7'd10}, 4'b0100, 1'b1, 4'b0001, "t6_rec");
      chk("t6_cnt_const", 32'(free_cnt), 32'd92);
      chk("t6_prd_const", 32'(alloc_prd4x), 32'({7'd43, 7'd42, 7'd41, 7'd40}));
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'b0100, "t6_rec2");
      chk("t6_rec2_cnt", 32'(free_cnt), 32'd96);
      chk("t6_rec2_prd", 32'(alloc_prd4x), 32'({7'd39, 7'd38, 7'd37, 7'd36}));
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, "t6_alloc_after");

      // Mid-operation reset
      do_reset("t7");
      idle("t7_idle");
      chk("t7_cnt_const", 32'(free_cnt), 32'd96);
      chk("t7_prd_const", 32'(alloc_prd4x), 32'({7'd35, 7'd34, 7'd33, 7'd32}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
